weights_fetch: RTL and testbench

WEIGHTS_FETCH -- requirements
Module: weights_fetch

---
 rtl/weights_fetch_pkg.sv | 13 +
 rtl/weights_fetch_fifo2.sv | 41 ++++
 rtl/weights_fetch.sv | 112 +++++++++++
 tb/tb_weights_fetch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/weights_fetch_pkg.sv
// Shared definitions for the weights fetch block: default widths and the controller state encoding.
package weights_fetch_pkg;

  localparam int W_DATA_DEF = 3;
  localparam int W_ADDR_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/weights_fetch_fifo2.sv
// Two-entry synchronous FIFO with occupancy output; a push into a full FIFO is legal only alongside a pop.
module fetch_fifo2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   occ,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign occ      = cnt;
  assign empty    = (cnt == 2'd0);

endmodule

// File: rtl/weights_fetch.sv
// Streams a block of words from a one-cycle-latency weights ROM onto a valid/ready interface.
module weights_fetch
  import weights_fetch_pkg::*;
#(
  parameter int W_DATA = W_DATA_DEF,
  parameter int W_ADDR = W_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_ADDR-1:0] base_addr,
  input  logic [W_ADDR:0]   count,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [W_ADDR-1:0] rom_addr,
  input  logic [W_DATA-1:0] rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W_DATA-1:0] m_data,
  output logic              m_last
);

  localparam logic [W_ADDR:0]   REM_ONE  = (W_ADDR+1)'(1);
  localparam logic [W_ADDR-1:0] ADDR_ONE = W_ADDR'(1);

  state_t            state;
  state_t            state_nxt;
  logic [W_ADDR-1:0] addr_p0;
  logic [W_ADDR:0]   rem_p0;
  logic              vld_p1;
  logic              last_p1;
  logic              done_q;
  logic [1:0]        occ;
  logic              fifo_empty;
  logic [W_DATA:0]   head;
  logic              issue;
  logic              pop;
  logic              launch;
  logic              zero_req;
  logic              finish;

  assign launch   = (state == IDLE) && start && (count != '0);
  assign zero_req = (state == IDLE) && start && (count == '0);
  assign pop      = m_valid && m_ready;
  assign finish   = pop && m_last;

  // A read is issued only if its word is guaranteed a FIFO slot when it lands.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_nxt = FETCH;
      end
      FETCH: begin
        issue = (({1'b0, occ} + {2'b0, vld_p1}) < (3'd2 + {2'b0, pop}));
        if (issue && (rem_p0 == REM_ONE)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (finish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_p0 <= '0;
      rem_p0  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_q  <= zero_req || finish;
      vld_p1  <= issue;
      last_p1 <= issue && (rem_p0 == REM_ONE);
      if (launch) begin
        addr_p0 <= base_addr;
        rem_p0  <= count;
      end else if (issue) begin
        addr_p0 <= addr_p0 + ADDR_ONE;
        rem_p0  <= rem_p0 - REM_ONE;
      end
    end
  end

  // p1 -> FIFO: ROM word lands one cycle after its read, tagged with the last flag.
  fetch_fifo2 #(
    .W(W_DATA + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data ({last_p1, rom_data}),
    .pop       (pop),
    .pop_data  (head),
    .occ       (occ),
    .empty     (fifo_empty)
  );

  assign busy     = !rst && (state != IDLE);
  assign done     = !rst && done_q;
  assign rom_en   = !rst && issue;
  assign rom_addr = rst ? '0 : addr_p0;
  assign m_valid  = !rst && !fifo_empty;
  assign m_data   = head[W_DATA-1:0];
  assign m_last   = m_valid && head[W_DATA];

endmodule

// File: tb/tb_weights_fetch.sv
// Bench for weights_fetch: ROM model, event recorder, and per-scenario checks against a block-level model.
module tb_weights_fetch;

  localparam int WD = 3;
  localparam int WA = 8;

  typedef struct {
    int          cyc;
    logic [WD-1:0] data;
    logic        last;
  } hs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [WA-1:0] base_addr = '0;
  logic [WA:0]   count = '0;
  logic          busy, done, rom_en, m_valid, m_last;
  logic [WA-1:0] rom_addr;
  logic [WD-1:0] rom_data;
  logic          m_ready = 1'b0;
  logic [WD-1:0] m_data;

  always #5 clk = ~clk;

  weights_fetch #(.W_DATA(WD), .W_ADDR(WA)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  logic [WD-1:0] rom [256];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  hs_t           got_q[$];
  hs_t           exp_q[$];
  logic [WA-1:0] addr_q[$];
  int            done_q[$];
  int            outst = 0, ovf_cnt = 0, stab_err = 0, vld_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [WD-1:0] prev_data;
  logic          prev_last;
  hs_t           h;

  // Recorder: logs what the DUT did each cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      outst = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stab_err++;
      if (rom_en && (outst - int'(m_valid && m_ready)) >= 2) ovf_cnt++;
      if (m_valid) vld_cnt++;
      if (m_valid && m_ready) begin
        h.cyc = cyc; h.data = m_data; h.last = m_last;
        got_q.push_back(h);
      end
      if (rom_en) addr_q.push_back(rom_addr);
      if (done) done_q.push_back(cyc);
      outst += int'(rom_en) - int'(m_valid && m_ready);
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_q.delete(); exp_q.delete(); addr_q.delete(); done_q.delete();
    ovf_cnt = 0; stab_err = 0; vld_cnt = 0;
  endtask

  // Block model: n words from consecutive addresses modulo 256, last flag on the n-th.
  task automatic add_block(input logic [WA-1:0] base, input int n);
    hs_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc = 0;
      e.data = rom[(int'(base) + i) % 256];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en got %b want 0", rom_en); end
    n_cmp++; if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL reset_rom_addr got %h want 00", rom_addr); end
    n_cmp++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin n_fail++; $display("FAIL reset_stream got v=%b l=%b want 0/0", m_valid, m_last); end
    clear_logs();
    base_addr = 8'h10; count = 9'd5; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    repeat (4) tick();
    n_cmp++; if (busy !== 1'b0 || addr_q.size() != 0) begin n_fail++; $display("FAIL reset_prio got busy=%b reads=%0d want 0/0", busy, addr_q.size()); end
  endtask

  task automatic test_stream();
    int t, k;
    clear_logs();
    m_ready = 1'b1; base_addr = 8'h00; count = 9'd5; start = 1'b1; t = cyc;
    tick(); start = 1'b0;
    k = 0;
    while (done_q.size() == 0 && k < 40) begin tick(); k++; end
    tick();
    add_block(8'h00, 5);
    n_cmp++; if (got_q.size() != 5) begin n_fail++; $display("FAIL stream_count got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last || got_q[i].cyc != t + 3 + i) begin
        n_fail++;
        $display("FAIL stream_word[%0d] got d=%h l=%b c=%0d want d=%h l=%b c=%0d", i, got_q[i].data, got_q[i].last, got_q[i].cyc, exp_q[i].data, exp_q[i].last, t + 3 + i);
      end
    end
    n_cmp++; if (done_q.size() != 1 || done_q[0] != t + 8) begin n_fail++; $display("FAIL stream_done got n=%0d c=%0d want n=1 c=%0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, t + 8); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_wrap();
    logic [WA-1:0] exp_a [4];
    int k;
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    clear_logs();
    m_ready = 1'b1; base_addr = 8'hFE; count = 9'd4; start = 1'b1;
    tick(); start = 1'b0;
    k = 0;
    while (done_q.size() == 0 && k < 40) begin tick(); k++; end
    add_block(8'hFE, 4);
    n_cmp++; if (addr_q.size() != 4) begin n_fail++; $display("FAIL wrap_reads got %0d want 4", addr_q.size()); end
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      n_cmp++; if (addr_q[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr[%0d] got %h want %h", i, addr_q[i], exp_a[i]); end
    end
    n_cmp++; if (got_q.size() != 4) begin n_fail++; $display("FAIL wrap_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin n_fail++; $display("FAIL wrap_word[%0d] got %h/%b want %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
  endtask

  task automatic test_backpressure();
    logic [WA-1:0] b;
    int n, k;
    for (int it = 0; it < 5; it++) begin
      clear_logs();
      b = WA'($urandom);
      n = (it == 0) ? 3 : int'($urandom_range(1, 12));
      base_addr = b; count = (WA+1)'(n); start = 1'b1; m_ready = 1'b1;
      tick(); start = 1'b0;
      k = 0;
      while (done_q.size() == 0 && k < 200) begin
        m_ready = (it == 0) ? (k % 3 == 2) : 1'($urandom);
        tick(); k++;
      end
      m_ready = 1'b1;
      tick();
      add_block(b, n);
      n_cmp++; if (got_q.size() != n) begin n_fail++; $display("FAIL bp%0d_count got %0d want %0d", it, got_q.size(), n); end
      for (int i = 0; i < n && i < got_q.size(); i++) begin
        n_cmp++; if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin n_fail++; $display("FAIL bp%0d_word[%0d] got %h/%b want %h/%b", it, i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last); end
      end
      n_cmp++; if (stab_err != 0) begin n_fail++; $display("FAIL bp%0d_stable got %0d changes want 0", it, stab_err); end
      n_cmp++; if (ovf_cnt != 0) begin n_fail++; $display("FAIL bp%0d_overissue got %0d want 0", it, ovf_cnt); end
      n_cmp++; if (done_q.size() != 1) begin n_fail++; $display("FAIL bp%0d_done got %0d pulses want 1", it, done_q.size()); end
    end
  endtask

  task automatic test_zero();
    int t;
    clear_logs();
    m_ready = 1'b1; base_addr = WA'($urandom); count = '0; start = 1'b1; t = cyc;
    tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy[%0d] got %b want 0", i, busy); end
      tick();
    end
    n_cmp++; if (addr_q.size() != 0) begin n_fail++; $display("FAIL zero_reads got %0d want 0", addr_q.size()); end
    n_cmp++; if (done_q.size() != 1 || done_q[0] != t + 1) begin n_fail++; $display("FAIL zero_done got n=%0d c=%0d want n=1 c=%0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, t + 1); end
  endtask

  task automatic test_reset_mid();
    int seen, k;
    clear_logs();
    m_ready = 1'b0; base_addr = WA'($urandom); count = 9'd6; start = 1'b1;
    tick(); start = 1'b0;
    seen = 0; k = 0;
    while (seen < 2 && k < 20) begin
      if (rom_en) seen++;
      if (seen < 2) tick();
      k++;
    end
    n_cmp++; if (seen != 2) begin n_fail++; $display("FAIL rstmid_reads got %0d want 2", seen); end
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || rom_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got b=%b d=%b e=%b want 0/0/0", busy, done, rom_en); end
    n_cmp++; if (rom_addr !== 8'h00 || m_valid !== 1'b0 || m_last !== 1'b0) begin n_fail++; $display("FAIL rstmid_out got a=%h v=%b l=%b want 00/0/0", rom_addr, m_valid, m_last); end
    clear_logs();
    m_ready = 1'b1;
    repeat (8) tick();
    n_cmp++; if (vld_cnt != 0 || got_q.size() != 0) begin n_fail++; $display("FAIL rstmid_stray got %0d valid cycles want 0", vld_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [WA-1:0] a, c;
    int k, tdone;
    clear_logs();
    a = WA'($urandom); c = WA'($urandom);
    m_ready = 1'b1; base_addr = a; count = 9'd4; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", busy); end
    base_addr = WA'($urandom); count = 9'd7; start = 1'b1;
    tick(); start = 1'b0;
    k = 0;
    while (!done && k < 30) begin tick(); k++; end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got %b want 1", done); end
    base_addr = c; count = 9'd3; start = 1'b1; tdone = cyc;
    tick(); start = 1'b0;
    k = 0;
    while (done_q.size() < 2 && k < 30) begin tick(); k++; end
    tick();
    add_block(a, 4);
    add_block(c, 3);
    n_cmp++; if (got_q.size() != 7) begin n_fail++; $display("FAIL b2b_count got %0d want 7", got_q.size()); end
    for (int i = 0; i < 7 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin n_fail++; $display("FAIL b2b_word[%0d] got %h/%b want %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    n_cmp++; if (got_q.size() > 4 && got_q[4].cyc != tdone + 3) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", got_q[4].cyc, tdone + 3); end
    n_cmp++; if (done_q.size() != 2) begin n_fail++; $display("FAIL b2b_done got %0d pulses want 2", done_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = WD'($urandom);
    test_reset();
    test_stream();
    test_wrap();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
